counter_cmd_arbiter: RTL and testbench

//  Shares one WIDTH-bit up/down counter between NREQ command requesters, such as

---
 rtl/counter_cmd_arbiter.sv | 152 +++++++++++++++
 tb/tb_counter_cmd_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter
//   Shares one WIDTH-bit up/down counter between NREQ command requesters,
//   served round-robin. A free-running prescaler can also autocount the
//   counter. Exported flags are registered one clock behind count.
//
// Ports
//   clk          in   clock, all logic on posedge
//   reset        in   asynchronous, active-high; clears all state
//   req          in   [NREQ]        per-requester request, held until ack
//   cmd          in   [2*NREQ]      cmd[2i+:2]: 00 reset, 01 up, 10 down, 11 load
//   load_val     in   [WIDTH*NREQ]  load_val[WIDTH*i+:WIDTH], used for load
//   autocount_en in   enables prescaler-driven increments
//   ack          out  [NREQ]        one-hot 1-clk pulse: command i executed
//   count        out  [WIDTH]       current counter value
//   tick         out  1-clk pulse when the prescaler reaches zero
//   eq_zero      out  registered (count == 0)
//   eq_max       out  registered (count == all ones)
//   tick_lost    out  sticky: an autocount tick was dropped
//
// state | meaning
// ARB   | look for a request starting at the round-robin pointer, capture it
// EXEC  | apply the captured command, pulse ack, advance the pointer
module counter_cmd_arbiter #(
  parameter int                NREQ     = 4,
  parameter int                WIDTH    = 8,
  parameter int                DIV_W    = 24,
  parameter logic [DIV_W-1:0]  DIV_LOAD = 24'h100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     cmd,
  input  logic [WIDTH*NREQ-1:0] load_val,
  input  logic                  autocount_en,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  eq_zero,
  output logic                  eq_max,
  output logic                  tick_lost
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, EXEC} state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   presc;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cap_idx;
  logic [1:0]         cap_cmd;
  logic [WIDTH-1:0]   cap_val;
  logic               pending;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   scan_idx;
  int                 scan;

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan     = (int'(ptr) + k) % NREQ;
      scan_idx = IDX_W'(scan);
      if (!grant_found && req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (grant_found) state_next = EXEC;
      EXEC:    state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= DIV_LOAD;
      tick  <= 1'b0;
    end else if (presc == '0) begin
      presc <= DIV_LOAD;
      tick  <= 1'b1;
    end else begin
      presc <= presc - DIV_W'(1);
      tick  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      ack       <= '0;
      ptr       <= '0;
      cap_idx   <= '0;
      cap_cmd   <= 2'b00;
      cap_val   <= '0;
      pending   <= 1'b0;
      tick_lost <= 1'b0;
      eq_zero   <= 1'b0;
      eq_max    <= 1'b0;
    end else begin
      ack     <= '0;
      eq_zero <= (count == '0);
      eq_max  <= (count == {WIDTH{1'b1}});
      if (state == EXEC) begin
        case (cap_cmd)
          2'b00:   count <= '0;
          2'b01:   count <= count + WIDTH'(1);
          2'b10:   count <= count - WIDTH'(1);
          default: count <= cap_val;
        endcase
        ack <= NREQ'(1) << cap_idx;
        ptr <= (cap_idx == IDX_W'(NREQ - 1)) ? '0 : cap_idx + IDX_W'(1);
        // A tick landing on EXEC is deferred; a counter-reset command wipes it.
        if (cap_cmd == 2'b00 || !autocount_en) begin
          pending <= 1'b0;
        end else if (tick) begin
          if (pending) tick_lost <= 1'b1;
          else         pending   <= 1'b1;
        end
      end else begin
        if (grant_found) begin
          cap_idx <= grant_idx;
          cap_cmd <= cmd[2*grant_idx +: 2];
          cap_val <= load_val[WIDTH*grant_idx +: WIDTH];
        end
        if (!autocount_en) begin
          pending <= 1'b0;
        end else begin
          // At most one increment per cycle; a tick on top of a pending one is lost.
          if (pending || tick) count <= count + WIDTH'(1);
          if (pending && tick) tick_lost <= 1'b1;
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
module tb_counter_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  cmd = '0;
  logic [31:0] load_val = '0;
  logic        autocount_en = 1'b0;
  logic [3:0]  ack;
  logic [7:0]  count;
  logic        tick, eq_zero, eq_max, tick_lost;

  logic [3:0]  fast_req = '0;
  logic        fast_en = 1'b0;
  logic [3:0]  fast_ack;
  logic [7:0]  fast_count;
  logic        fast_tick, fast_eq_zero, fast_eq_max, fast_lost;

  int checks = 0;
  int errors = 0;

  typedef struct {int idx; logic [7:0] cnt;} exp_t;
  exp_t       sb[$];
  exp_t       e;
  logic [7:0] model_count = '0;

  always #5 clk = ~clk;

  counter_cmd_arbiter #(.NREQ(4), .WIDTH(8), .DIV_W(24), .DIV_LOAD(24'd15)) dut (
    .clk(clk), .reset(rst), .req(req), .cmd(cmd), .load_val(load_val),
    .autocount_en(autocount_en), .ack(ack), .count(count), .tick(tick),
    .eq_zero(eq_zero), .eq_max(eq_max), .tick_lost(tick_lost)
  );

  // Prescaler reloading with 0 ticks every clock.
  counter_cmd_arbiter #(.NREQ(4), .WIDTH(8), .DIV_W(24), .DIV_LOAD(24'd0)) u_fast (
    .clk(clk), .reset(rst), .req(fast_req), .cmd(8'h55), .load_val(32'h0),
    .autocount_en(fast_en), .ack(fast_ack), .count(fast_count), .tick(fast_tick),
    .eq_zero(fast_eq_zero), .eq_max(fast_eq_max), .tick_lost(fast_lost)
  );

  // Scoreboard: every ack must match the oldest expected (requester, count).
  always @(negedge clk) begin
    if (!rst && ack !== 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected ack=%b count=%h, no command outstanding", ack, count);
      end else begin
        e = sb.pop_front();
        if (ack !== (4'b1 << e.idx) || count !== e.cnt) begin
          errors++;
          $display("FAIL sb_ack got ack=%b count=%h want ack=%b count=%h",
                   ack, count, 4'b1 << e.idx, e.cnt);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0; fast_req = '0; autocount_en = 1'b0; fast_en = 1'b0;
    sb.delete();
    model_count = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_cmd(input int i, input logic [1:0] c, input logic [7:0] v);
    int lat;
    bit got;
    case (c)
      2'b00:   model_count = '0;
      2'b01:   model_count = model_count + 8'd1;
      2'b10:   model_count = model_count - 8'd1;
      default: model_count = v;
    endcase
    sb.push_back('{i, model_count});
    cmd[2*i +: 2] = c;
    load_val[8*i +: 8] = v;
    req[i] = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10 && !got; n++) begin
      @(negedge clk);
      if (ack[i]) begin got = 1'b1; lat = n; end
    end
    req[i] = 1'b0;
    checks++;
    if (!got || lat != 2) begin
      errors++;
      $display("FAIL cmd_latency req=%0d got=%0d latency=%0d want 2", i, got, lat);
    end
  endtask

  task automatic test_reset();
    int t_first, t_second;
    bit quiet;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 8'h00 || ack !== 4'b0 || eq_zero !== 1'b0 || eq_max !== 1'b0 ||
        tick !== 1'b0 || tick_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_values count=%h ack=%b eqz=%b eqm=%b tick=%b lost=%b want all 0",
               count, ack, eq_zero, eq_max, tick, tick_lost);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (eq_zero !== 1'b0) begin
      errors++; $display("FAIL eq_zero_at_release got=%b want 0", eq_zero);
    end
    @(negedge clk);
    checks++;
    if (eq_zero !== 1'b1) begin
      errors++; $display("FAIL eq_zero_after_release got=%b want 1", eq_zero);
    end
    quiet = 1'b1; t_first = -1; t_second = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (count !== 8'h00 || ack !== 4'b0) quiet = 1'b0;
      if (tick) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL idle_quiet count=%h ack=%b want 00/0000", count, ack);
    end
    checks++;
    if (t_first < 0 || t_second - t_first != 16) begin
      errors++; $display("FAIL tick_period got=%0d want 16", t_second - t_first);
    end
  endtask

  task automatic test_load_wrap();
    apply_reset();
    do_cmd(1, 2'b11, 8'hFE);
    do_cmd(1, 2'b01, 8'h00);
    checks++;
    if (eq_max !== 1'b0) begin
      errors++; $display("FAIL eq_max_lag got=%b want 0 in count=FF cycle", eq_max);
    end
    @(negedge clk);
    checks++;
    if (eq_max !== 1'b1 || count !== 8'hFF) begin
      errors++; $display("FAIL eq_max got=%b count=%h want 1/FF", eq_max, count);
    end
    do_cmd(1, 2'b01, 8'h00);
    @(negedge clk);
    checks++;
    if (eq_zero !== 1'b1 || eq_max !== 1'b0 || count !== 8'h00) begin
      errors++; $display("FAIL wrap_up eqz=%b eqm=%b count=%h want 1/0/00", eq_zero, eq_max, count);
    end
    do_cmd(2, 2'b10, 8'h00);
    do_cmd(3, 2'b11, 8'h3C);
    do_cmd(0, 2'b00, 8'h00);
  endtask

  task automatic test_back_to_back();
    int last, n;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cmd[2*i +: 2] = 2'b01;
      sb.push_back('{i, 8'(i + 1)});
    end
    model_count = 8'd4;
    req = 4'b1111;
    last = -1; n = 0;
    for (int c = 1; c <= 20 && req != 4'b0; c++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        checks++;
        if ((last < 0 && c != 2) || (last >= 0 && c - last != 2)) begin
          errors++; $display("FAIL b2b_spacing ack#%0d at cycle %0d prev %0d want gap 2", n, c, last);
        end
        last = c;
        req = req & ~ack;
        n++;
      end
    end
    req = '0;
    checks++;
    if (n != 4 || count !== 8'd4) begin
      errors++; $display("FAIL b2b_total acks=%0d count=%h want 4/04", n, count);
    end
  endtask

  task automatic test_fairness();
    int last, n;
    bit raise;
    apply_reset();
    cmd = 8'h55;
    for (int k = 0; k < 8; k++) sb.push_back('{(k % 2 == 0) ? 0 : 2, 8'(k + 1)});
    model_count = 8'd8;
    req = 4'b0101;
    last = -1; n = 0; raise = 1'b0;
    for (int c = 1; c <= 40 && n < 8; c++) begin
      @(negedge clk);
      if (raise) begin req[2] = 1'b1; raise = 1'b0; end
      if (ack != 4'b0) begin
        checks++;
        if (ack[0] && last == 0) begin
          errors++; $display("FAIL fairness two acks to req0 at ack#%0d while req2 waits", n);
        end
        last = ack[0] ? 0 : 2;
        if (ack[2]) begin req[2] = 1'b0; raise = 1'b1; end
        n++;
        if (n == 8) req = '0;
      end
    end
    req = '0;
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL fairness_timeout acks=%0d want 8", n);
    end
  endtask

  task automatic test_autocount();
    bit found;
    apply_reset();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (tick) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL tick_timeout got no tick want one within 40 clks");
    end
    @(negedge clk);
    autocount_en = 1'b1;
    repeat (14) @(negedge clk);
    cmd[1:0] = 2'b01;
    sb.push_back('{0, 8'd1});
    req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (tick !== 1'b1) begin
      errors++; $display("FAIL tick_align tick=%b want 1 in EXEC cycle", tick);
    end
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 8'd2 || tick_lost !== 1'b0) begin
      errors++; $display("FAIL pending_inc count=%h lost=%b want 02/0", count, tick_lost);
    end
    autocount_en = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (count !== 8'd2) begin
      errors++; $display("FAIL autocount_off count=%h want 02", count);
    end
    // Tick every clock: the deferred increment collides with the next tick.
    fast_en = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (fast_lost !== 1'b0) begin
      errors++; $display("FAIL lost_idle got=%b want 0", fast_lost);
    end
    fast_req[0] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (fast_ack[0]) found = 1'b1;
    end
    fast_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (!found || fast_lost !== 1'b1) begin
      errors++; $display("FAIL tick_lost ack_seen=%b lost=%b want 1/1", found, fast_lost);
    end
    fast_en = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    bit quiet;
    apply_reset();
    do_cmd(2, 2'b11, 8'h33);
    @(negedge clk);
    cmd[3:2] = 2'b11;
    load_val[15:8] = 8'h5A;
    req[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 8'h00 || ack !== 4'b0) begin
      errors++; $display("FAIL reset_in_exec count=%h ack=%b want 00/0000", count, ack);
    end
    req = '0;
    sb.delete();
    model_count = '0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ack !== 4'b0 || count !== 8'h00) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL reset_hold ack=%b count=%h want 0000/00", ack, count);
    end
    cmd = 8'h55;
    sb.push_back('{0, 8'd1});
    sb.push_back('{1, 8'd2});
    model_count = 8'd2;
    req = 4'b0011;
    rst = 1'b0;
    for (int c = 1; c <= 12 && req != 4'b0; c++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        if (req == 4'b0011) begin
          checks++;
          if (ack !== 4'b0001 || c != 2) begin
            errors++; $display("FAIL first_after_reset ack=%b cycle=%0d want 0001 at 2", ack, c);
          end
        end
        req = req & ~ack;
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0 || count !== 8'd2) begin
      errors++; $display("FAIL after_reset_drain left=%0d count=%h want 0/02", sb.size(), count);
    end
  endtask

  initial begin
    test_reset();
    test_load_wrap();
    test_back_to_back();
    test_fairness();
    test_autocount();
    test_reset_mid_exec();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain outstanding=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
